feistel_round_ctrl: RTL

Iterative round controller for the 64-bit, four-lane (4×16) Feistel datapath. It accepts a plaintext block and a 64-bit master key over a valid/ready handshake. It then drives the combinational round stage once per clock with the current lanes and a 32-bit round key, and registers the round stage's outputs back as the next state. After `ROUNDS` iterations it presents the result over a second valid/ready handshake. It sits directly upstream and downstream of the round stage: it both feeds that stage and consumes what it produces.

---
 rtl/feistel_pkg.sv | 23 ++
 rtl/feistel_key_sched.sv | 43 ++++
 rtl/feistel_round_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/feistel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : feistel_pkg                                            |
// | Description : Shared widths, key rotation amount and FSM encoding    |
// |               for the iterative 4x16 Feistel round controller.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package feistel_pkg;

  localparam int LANE_W  = 16;
  localparam int BLK_W   = 64;
  localparam int KEY_W   = 64;
  localparam int TT_W    = 32;
  localparam int KEY_ROT = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/feistel_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : feistel_key_sched                                      |
// | Description : Holds the 64-bit working key, loads it on block accept |
// |               and rotates it left by KEY_ROT each round. The round   |
// |               key is the upper 32 bits XOR the 4-bit round index.    |
// | Ports       : clk, rst (async, active-high)                          |
// |               load   - capture key_in                                |
// |               adv    - rotate key for next round                     |
// |               key_in - master key, MSB-first                         |
// |               rnd    - current round index                           |
// |               tt     - round key to the round stage                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module feistel_key_sched
  import feistel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [KEY_W-1:0] key_in,
  input  logic [3:0]       rnd,
  output logic [TT_W-1:0]  tt
);

  logic [KEY_W-1:0] r_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
    end else if (load) begin
      r_key <= key_in;
    end else if (adv) begin
      r_key <= {r_key[KEY_W-KEY_ROT-1:0], r_key[KEY_W-1:KEY_W-KEY_ROT]};
    end
  end

  // Key bits [0:31] in MSB-first numbering are the top half of the vector.
  assign tt = r_key[KEY_W-1 -: TT_W] ^ {{(TT_W-4){1'b0}}, rnd};

endmodule
`default_nettype wire

// File: rtl/feistel_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : feistel_round_ctrl                                     |
// | Description : Iterative round controller. Accepts a block and key,   |
// |               drives the external combinational round stage once per |
// |               clock for ROUNDS iterations, then offers the result.   |
// | Ports       : clk, rst (async, active-high)                          |
// |               in_valid/in_ready/in_block/in_key   - input handshake  |
// |               rnd_w0..3, rnd_tt                   - to round stage   |
// |               rnd_y0..3                           - from round stage |
// |               out_valid/out_ready/out_block       - output handshake |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module feistel_round_ctrl
  import feistel_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in_block,
  input  logic [KEY_W-1:0]  in_key,
  output logic [LANE_W-1:0] rnd_w0,
  output logic [LANE_W-1:0] rnd_w1,
  output logic [LANE_W-1:0] rnd_w2,
  output logic [LANE_W-1:0] rnd_w3,
  output logic [TT_W-1:0]   rnd_tt,
  input  logic [LANE_W-1:0] rnd_y0,
  input  logic [LANE_W-1:0] rnd_y1,
  input  logic [LANE_W-1:0] rnd_y2,
  input  logic [LANE_W-1:0] rnd_y3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_block
);

  localparam logic [3:0] C_LAST_RND = 4'(ROUNDS - 1);

  state_t           r_st;
  state_t           w_st_nxt;
  logic [BLK_W-1:0] r_s;
  logic [3:0]       r_rnd;
  logic             w_load;
  logic             w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= IDLE;
    end else begin
      r_st <= w_st_nxt;
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load   = 1'b1;
          w_st_nxt = RUN;
        end
      end
      RUN: begin
        w_adv = 1'b1;
        if (r_rnd == C_LAST_RND) begin
          w_st_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_st_nxt = IDLE;
        end
      end
      default: w_st_nxt = IDLE;
    endcase
  end

  // Lane 0 sits in the most significant 16 bits (MSB-first packing).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s   <= '0;
      r_rnd <= '0;
    end else if (w_load) begin
      r_s   <= in_block;
      r_rnd <= '0;
    end else if (w_adv) begin
      r_s   <= {rnd_y0, rnd_y1, rnd_y2, rnd_y3};
      r_rnd <= r_rnd + 4'd1;
    end
  end

  feistel_key_sched u_key_sched (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .adv    (w_adv),
    .key_in (in_key),
    .rnd    (r_rnd),
    .tt     (rnd_tt)
  );

  assign rnd_w0    = r_s[BLK_W-1          -: LANE_W];
  assign rnd_w1    = r_s[BLK_W-1-LANE_W   -: LANE_W];
  assign rnd_w2    = r_s[BLK_W-1-2*LANE_W -: LANE_W];
  assign rnd_w3    = r_s[BLK_W-1-3*LANE_W -: LANE_W];
  // S only changes in IDLE (load) and RUN, so it is stable throughout DONE.
  assign out_block = r_s;

endmodule
`default_nettype wire
